alu_issue_arbiter: RTL and testbench
====================================

Name: alu_issue_arbiter

Overview:
- Shares one alu64 instance between NUM_REQ requesters using fair round-robin issue.
- Registers the winning operation into the ALU and tracks every in-flight op by requester id and tag.
- Returns each ALU result to its owner on a single tagged response bus.
- A flush handshake stops new issue, drains the pipeline, then acknowledges; used ahead of mode changes and for context switch.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- ALU_LAT, 1: cycles from alu_valid to a valid alu_result (fixed alu64 pipeline depth).
- TAG_W, 4: requester tag width, returned unchanged with the result.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous reset, active-low (rst=0 resets on the clk rising edge).
- req_valid  in  NUM_REQ  per-requester op valid.
- req_ready  out  NUM_REQ  per-requester grant, one-hot or zero.
- req_op_a  in  NUM_REQ*64  operand A, requester i at [64i+63:64i].
- req_op_b  in  NUM_REQ*64  operand B, packed the same way.
- req_opcode  in  NUM_REQ*4  alu64 opcode per requester.
- req_tag  in  NUM_REQ*TAG_W  requester tag.
- alu_valid  out  1  to alu64 valid.
- alu_op_a  out  64  to alu64 op_a.
- alu_op_b  out  64  to alu64 op_b.
- alu_opcode  out  4  to alu64 opcode.
- alu_result  in  64  from alu64 result.
- resp_valid  out  1  response valid, one cycle per op, no backpressure.
- resp_id  out  $clog2(NUM_REQ)  owning requester.
- resp_tag  out  TAG_W  echoed tag.
- resp_result  out  64  ALU result.
- flush_req  in  1  level; request drain.
- flush_done  out  1  one-cycle pulse when drained.
- busy  out  1  ops in flight.

Behaviour:
- Reset (rst=0 at edge):
  - All outputs 0; alu_op_a, alu_op_b, alu_opcode cleared to 0.
  - Round-robin pointer = 0; state = RUN; in-flight tracker cleared.
  - Ops in flight at reset are discarded and produce no response.
- Handshake:
  - req_ready is combinational.
  - An op transfers in cycle N when req_valid[i] and req_ready[i] are both 1.
  - req_ready is all-zero when state != RUN or flush_req=1.
  - Requesters hold valid and data stable until ready.
- Arbitration:
  - Search from the pointer upward, wrapping modulo NUM_REQ; the first valid requester wins.
  - After a grant to i, pointer = (i+1) mod NUM_REQ.
  - With no grant, the pointer holds.
  - Throughput is 1 op per cycle.
- Issue:
  - Cycle N+1: alu_valid=1, and alu_op_a, alu_op_b, alu_opcode carry the granted op.
  - With no grant in N, alu_valid=0 in N+1 and the data outputs hold their previous values.
- Tracking:
  - A shift register of depth ALU_LAT+1 carries {valid, id, tag} alongside the ALU.
  - Its tail aligns with alu_result in cycle N+1+ALU_LAT.
- Response:
  - Registered; resp_valid=1 in cycle N+2+ALU_LAT with resp_id, resp_tag, resp_result.
  - Handshake-to-response latency = ALU_LAT+2 (3 at default).
  - Responses arrive in issue order.
  - resp_id, resp_tag, resp_result hold when resp_valid=0.
- In-flight count:
  - Range 0..ALU_LAT+2.
  - Increments on handshake, decrements on resp_valid.
  - Simultaneous increment and decrement leaves it unchanged.
  - busy = (count != 0).
- FSM (RUN, DRAIN, HOLD):
  - RUN -> DRAIN when flush_req=1 (no grant that cycle).
  - DRAIN -> HOLD in the first cycle where count==0 and no response is pending; flush_done=1 for exactly that cycle.
  - HOLD -> RUN when flush_req=0.
  - If flush_req drops during DRAIN, the drain still completes: flush_done pulses, then RUN follows one cycle later.
  - flush_req=1 with count already 0 gives DRAIN for 1 cycle, then flush_done.

Decomposition:
- alu_ctrl_pkg:
  - opcode constants (ADD=4'b0000, SUB=4'b0001, and the remaining alu64 encodings);
  - state enum arb_state_e {RUN, DRAIN, HOLD};
  - function for the id width;
  - in-flight entry struct {valid, id, tag}.
- One sub-module, rr_arbiter: parameter N, inputs req[N] and en, outputs one-hot gnt[N] and gnt_id; owns the pointer register.

Test Plan:
- Single op: requester 2 sends op_a=5, op_b=3, opcode=ADD, tag=7 (handshake cycle N) -> alu_valid=1 at N+1; at N+3 resp_valid=1, resp_id=2, resp_tag=7, resp_result=0x8.
- Round-robin: all four requesters hold valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3; responses appear in the same order, one per cycle.
- Fairness after a gap: pointer=1, only requesters 0 and 3 valid -> 3 granted first, then 0.
- Back-to-back from one requester: SUB 5-3 then ADD 5+3, tags 1 and 2 -> consecutive responses 0x2/tag 1, then 0x8/tag 2; busy=1 throughout, 0 after.
- Flush with 2 ops in flight: assert flush_req -> req_ready=0 immediately; both responses delivered; flush_done pulses the cycle count reaches 0; release flush_req -> RUN and grants resume.
- Reset mid-flight: rst=0 one cycle after a grant -> no resp_valid ever for that op; all outputs 0 next cycle; pointer=0.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU issue arbiter.
// Opcode encodings, arbiter state and in-flight tracking entry.
package alu_ctrl_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;

    // Widest id (8 requesters) and tag the tracker can carry.
    localparam int ID_MAX_W  = 3;
    localparam int TAG_MAX_W = 16;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HOLD
    } arb_state_e;

    typedef struct packed {
        logic                 valid;
        logic [ID_MAX_W-1:0]  id;
        logic [TAG_MAX_W-1:0] tag;
    } inflight_t;

    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with an internal rotating priority pointer.
// Grants at most one requester per cycle when enabled.
module rr_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = id_w(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id
);

    logic [IW-1:0] ptr;
    logic [IW:0]   cand;
    logic          found;

    // Scan upward from the pointer, wrapping, first valid wins.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            if (!found && en && req[cand[IW-1:0]]) begin
                found                = 1'b1;
                gnt[cand[IW-1:0]]    = 1'b1;
                gnt_id               = cand[IW-1:0];
            end
        end
    end

    // Move priority just past the winner; hold when idle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr <= '0;
        end else if (found) begin
            if (gnt_id == IW'(N - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= gnt_id + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Shares one alu64 between requesters with round-robin issue,
// tagged in-order responses and a flush/drain handshake.
module alu_issue_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ALU_LAT = 1,
    parameter int TAG_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*64-1:0]      req_op_a,
    input  logic [NUM_REQ*64-1:0]      req_op_b,
    input  logic [NUM_REQ*4-1:0]       req_opcode,
    input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
    output logic                       alu_valid,
    output logic [63:0]                alu_op_a,
    output logic [63:0]                alu_op_b,
    output logic [3:0]                 alu_opcode,
    input  logic [63:0]                alu_result,
    output logic                       resp_valid,
    output logic [$clog2(NUM_REQ)-1:0] resp_id,
    output logic [TAG_W-1:0]           resp_tag,
    output logic [63:0]                resp_result,
    input  logic                       flush_req,
    output logic                       flush_done,
    output logic                       busy
);

    localparam int IW = id_w(NUM_REQ);
    localparam int CW = $clog2(ALU_LAT + 3);

    arb_state_e       state;
    arb_state_e       state_nx;
    logic             en;
    logic             issue;
    logic [NUM_REQ-1:0] gnt;
    logic [IW-1:0]    gnt_id;
    int               sel;
    logic [CW-1:0]    count;
    inflight_t        pipe [ALU_LAT+1];
    inflight_t        tail;
    logic             unused_bits;

    // Issue is only open in RUN with no flush pending and out of reset.
    assign en        = rst && (state == RUN) && !flush_req;
    assign req_ready = gnt;
    assign issue     = |gnt;
    assign sel       = int'(gnt_id);
    assign tail      = pipe[ALU_LAT];
    assign busy      = (count != '0);
    assign unused_bits = ^{tail.id, tail.tag};

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .clk    (clk),
        .rst    (rst),
        .req    (req_valid),
        .en     (en),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    // Register the winning op into the ALU; data holds when idle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            alu_valid  <= 1'b0;
            alu_op_a   <= '0;
            alu_op_b   <= '0;
            alu_opcode <= '0;
        end else begin
            alu_valid <= issue;
            if (issue) begin
                alu_op_a   <= req_op_a[sel*64 +: 64];
                alu_op_b   <= req_op_b[sel*64 +: 64];
                alu_opcode <= req_opcode[sel*4 +: 4];
            end
        end
    end

    // Owner/tag shift register running alongside the ALU pipeline.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k <= ALU_LAT; k++) begin
                pipe[k] <= '0;
            end
        end else begin
            pipe[0] <= '{
                valid: issue,
                id:    ID_MAX_W'(gnt_id),
                tag:   TAG_MAX_W'(req_tag[sel*TAG_W +: TAG_W])
            };
            for (int k = 1; k <= ALU_LAT; k++) begin
                pipe[k] <= pipe[k-1];
            end
        end
    end

    // Capture the ALU result with its owner when the tail is valid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            resp_valid  <= 1'b0;
            resp_id     <= '0;
            resp_tag    <= '0;
            resp_result <= '0;
        end else begin
            resp_valid <= tail.valid;
            if (tail.valid) begin
                resp_id     <= tail.id[IW-1:0];
                resp_tag    <= tail.tag[TAG_W-1:0];
                resp_result <= alu_result;
            end
        end
    end

    // Ops between handshake and response.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (issue && !resp_valid) begin
            count <= count + 1'b1;
        end else if (!issue && resp_valid) begin
            count <= count - 1'b1;
        end
    end

    // Flush state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= state_nx;
        end
    end

    // Flush sequencing; flush_done marks the drained cycle.
    always_comb begin
        state_nx   = state;
        flush_done = 1'b0;
        unique case (state)
            RUN: begin
                if (flush_req) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (count == '0 && !resp_valid) begin
                    state_nx   = HOLD;
                    flush_done = 1'b1;
                end
            end
            HOLD: begin
                if (!flush_req) begin
                    state_nx = RUN;
                end
            end
            default: state_nx = RUN;
        endcase
    end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed bench for alu_issue_arbiter with a small alu64 model.
// Each task drives one scenario and checks hand-computed values.
module tb_alu_issue_arbiter;
    import alu_ctrl_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [255:0] req_op_a;
    logic [255:0] req_op_b;
    logic [15:0]  req_opcode;
    logic [15:0]  req_tag;
    logic         alu_valid;
    logic [63:0]  alu_op_a;
    logic [63:0]  alu_op_b;
    logic [3:0]   alu_opcode;
    logic [63:0]  alu_result;
    logic         resp_valid;
    logic [1:0]   resp_id;
    logic [3:0]   resp_tag;
    logic [63:0]  resp_result;
    logic         flush_req;
    logic         flush_done;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    alu_issue_arbiter #(
        .NUM_REQ (4),
        .ALU_LAT (1),
        .TAG_W   (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op_a    (req_op_a),
        .req_op_b    (req_op_b),
        .req_opcode  (req_opcode),
        .req_tag     (req_tag),
        .alu_valid   (alu_valid),
        .alu_op_a    (alu_op_a),
        .alu_op_b    (alu_op_b),
        .alu_opcode  (alu_opcode),
        .alu_result  (alu_result),
        .resp_valid  (resp_valid),
        .resp_id     (resp_id),
        .resp_tag    (resp_tag),
        .resp_result (resp_result),
        .flush_req   (flush_req),
        .flush_done  (flush_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // One-cycle alu64 stand-in.
    always @(posedge clk) begin
        if (alu_valid) begin
            case (alu_opcode)
                OP_ADD:  alu_result <= alu_op_a + alu_op_b;
                OP_SUB:  alu_result <= alu_op_a - alu_op_b;
                OP_AND:  alu_result <= alu_op_a & alu_op_b;
                OP_OR:   alu_result <= alu_op_a | alu_op_b;
                OP_XOR:  alu_result <= alu_op_a ^ alu_op_b;
                default: alu_result <= 64'd0;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        req_valid  = '0;
        req_op_a   = '0;
        req_op_b   = '0;
        req_opcode = '0;
        req_tag    = '0;
    endtask

    task automatic set_req(input int i, input logic [63:0] a,
                           input logic [63:0] b, input logic [3:0] op,
                           input logic [3:0] tag);
        req_valid[i]         = 1'b1;
        req_op_a[i*64 +: 64] = a;
        req_op_b[i*64 +: 64] = b;
        req_opcode[i*4 +: 4] = op;
        req_tag[i*4 +: 4]    = tag;
    endtask

    task automatic do_reset();
        clear_reqs();
        flush_req = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        clear_reqs();
        flush_req = 1'b0;
        req_valid = 4'hF;
        rst = 1'b0;
        step();
        step();
        n_checks++;
        if (req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_ready got=%b want=0000", req_ready);
        end
        n_checks++;
        if (alu_valid !== 1'b0 || alu_op_a !== 64'd0) begin
            n_fail++;
            $display("FAIL rst_alu got=%b/%h want=0/0", alu_valid, alu_op_a);
        end
        n_checks++;
        if (resp_valid !== 1'b0 || resp_result !== 64'd0) begin
            n_fail++;
            $display("FAIL rst_resp got=%b/%h want=0/0", resp_valid, resp_result);
        end
        n_checks++;
        if (busy !== 1'b0 || flush_done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_busy got=%b/%b want=0/0", busy, flush_done);
        end
        rst = 1'b1;
        req_valid = '0;
        step();
    endtask

    task automatic test_single();
        do_reset();
        set_req(2, 64'd5, 64'd3, OP_ADD, 4'd7);
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_ready got=%b want=0100", req_ready);
        end
        step();
        clear_reqs();
        n_checks++;
        if (alu_valid !== 1'b1 || alu_op_a !== 64'd5 || alu_op_b !== 64'd3
            || alu_opcode !== OP_ADD) begin
            n_fail++;
            $display("FAIL single_issue got=%b %h %h %h want=1 5 3 0",
                     alu_valid, alu_op_a, alu_op_b, alu_opcode);
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_busy got=%b want=1", busy);
        end
        step();
        n_checks++;
        if (resp_valid !== 1'b0 || alu_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_early got=%b/%b want=0/0", resp_valid, alu_valid);
        end
        step();
        n_checks++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_tag !== 4'd7
            || resp_result !== 64'h8) begin
            n_fail++;
            $display("FAIL single_resp got=%b %0d %0d %h want=1 2 7 8",
                     resp_valid, resp_id, resp_tag, resp_result);
        end
        step();
        n_checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || resp_result !== 64'h8) begin
            n_fail++;
            $display("FAIL single_after got=%b %b %h want=0 0 8",
                     resp_valid, busy, resp_result);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_req(i, 64'(i + 1), 64'd100, OP_ADD, 4'(i + 8));
        end
        for (int c = 0; c < 12; c++) begin
            logic [3:0] exp_rdy;
            int g;
            exp_rdy = 4'(1 << (c % 4));
            g = (c - 3) % 4;
            if (c == 8) clear_reqs();
            #1;
            if (c < 8) begin
                n_checks++;
                if (req_ready !== exp_rdy) begin
                    n_fail++;
                    $display("FAIL rr_grant c=%0d got=%b want=%b", c, req_ready, exp_rdy);
                end
            end
            if (c >= 3 && c <= 10) begin
                n_checks++;
                if (resp_valid !== 1'b1 || resp_id !== 2'(g)
                    || resp_tag !== 4'(g + 8) || resp_result !== 64'(101 + g)) begin
                    n_fail++;
                    $display("FAIL rr_resp c=%0d got=%b %0d %0d %0d want=1 %0d %0d %0d",
                             c, resp_valid, resp_id, resp_tag, resp_result,
                             g, g + 8, 101 + g);
                end
            end
            if (c == 11) begin
                n_checks++;
                if (resp_valid !== 1'b0 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rr_idle got=%b/%b want=0/0", resp_valid, busy);
                end
            end
            step();
        end
    endtask

    task automatic test_fairness();
        do_reset();
        set_req(0, 64'd1, 64'd1, OP_ADD, 4'd0);
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL fair_first got=%b want=0001", req_ready);
        end
        step();
        clear_reqs();
        step();
        set_req(0, 64'd10, 64'd1, OP_ADD, 4'd1);
        set_req(3, 64'd20, 64'd1, OP_ADD, 4'd3);
        #1;
        n_checks++;
        if (req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL fair_wrap got=%b want=1000", req_ready);
        end
        step();
        req_valid[3] = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL fair_next got=%b want=0001", req_ready);
        end
        step();
        clear_reqs();
        step();
        n_checks++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd3 || resp_result !== 64'd21) begin
            n_fail++;
            $display("FAIL fair_resp3 got=%b %0d %0d want=1 3 21",
                     resp_valid, resp_id, resp_result);
        end
        step();
        n_checks++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_result !== 64'd11) begin
            n_fail++;
            $display("FAIL fair_resp0 got=%b %0d %0d want=1 0 11",
                     resp_valid, resp_id, resp_result);
        end
        step();
    endtask

    task automatic test_back_to_back();
        set_req(1, 64'd5, 64'd3, OP_SUB, 4'd1);
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL b2b_rdy0 got=%b want=0010", req_ready);
        end
        step();
        set_req(1, 64'd5, 64'd3, OP_ADD, 4'd2);
        #1;
        n_checks++;
        if (req_ready !== 4'b0010 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_rdy1 got=%b/%b want=0010/1", req_ready, busy);
        end
        step();
        clear_reqs();
        n_checks++;
        if (busy !== 1'b1 || resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_mid got=%b/%b want=1/0", busy, resp_valid);
        end
        step();
        n_checks++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_tag !== 4'd1
            || resp_result !== 64'h2 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_resp1 got=%b %0d %0d %h %b want=1 1 1 2 1",
                     resp_valid, resp_id, resp_tag, resp_result, busy);
        end
        step();
        n_checks++;
        if (resp_valid !== 1'b1 || resp_tag !== 4'd2 || resp_result !== 64'h8
            || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_resp2 got=%b %0d %h %b want=1 2 8 1",
                     resp_valid, resp_tag, resp_result, busy);
        end
        step();
        n_checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end got=%b/%b want=0/0", resp_valid, busy);
        end
    endtask

    task automatic test_flush();
        set_req(2, 64'd7, 64'd2, OP_SUB, 4'd4);
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL fl_rdy2 got=%b want=0100", req_ready);
        end
        step();
        clear_reqs();
        set_req(3, 64'd1, 64'd2, OP_ADD, 4'd5);
        #1;
        n_checks++;
        if (req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL fl_rdy3 got=%b want=1000", req_ready);
        end
        step();
        clear_reqs();
        set_req(0, 64'd9, 64'd9, OP_ADD, 4'd6);
        flush_req = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0000 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL fl_block got=%b/%b want=0000/1", req_ready, busy);
        end
        step();
        n_checks++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_result !== 64'd5
            || flush_done !== 1'b0) begin
            n_fail++;
            $display("FAIL fl_resp2 got=%b %0d %0d %b want=1 2 5 0",
                     resp_valid, resp_id, resp_result, flush_done);
        end
        step();
        n_checks++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd3 || resp_result !== 64'd3
            || flush_done !== 1'b0) begin
            n_fail++;
            $display("FAIL fl_resp3 got=%b %0d %0d %b want=1 3 3 0",
                     resp_valid, resp_id, resp_result, flush_done);
        end
        step();
        n_checks++;
        if (flush_done !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fl_done got=%b %b %b want=1 0 0",
                     flush_done, busy, resp_valid);
        end
        step();
        n_checks++;
        if (flush_done !== 1'b0 || req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL fl_hold got=%b/%b want=0/0000", flush_done, req_ready);
        end
        flush_req = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL fl_hold_rel got=%b want=0000", req_ready);
        end
        step();
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL fl_resume got=%b want=0001", req_ready);
        end
        step();
        clear_reqs();
        n_checks++;
        if (alu_valid !== 1'b1 || alu_op_a !== 64'd9) begin
            n_fail++;
            $display("FAIL fl_issue got=%b/%0d want=1/9", alu_valid, alu_op_a);
        end
        step();
        step();
        n_checks++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_tag !== 4'd6
            || resp_result !== 64'd18) begin
            n_fail++;
            $display("FAIL fl_resp0 got=%b %0d %0d %0d want=1 0 6 18",
                     resp_valid, resp_id, resp_tag, resp_result);
        end
        step();
    endtask

    task automatic test_reset_midflight();
        set_req(1, 64'd4, 64'd4, OP_OR, 4'd9);
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL mr_rdy got=%b want=0010", req_ready);
        end
        step();
        clear_reqs();
        n_checks++;
        if (alu_valid !== 1'b1 || alu_opcode !== OP_OR) begin
            n_fail++;
            $display("FAIL mr_issue got=%b/%h want=1/3", alu_valid, alu_opcode);
        end
        rst = 1'b0;
        step();
        rst = 1'b1;
        n_checks++;
        if (alu_valid !== 1'b0 || alu_op_a !== 64'd0 || alu_op_b !== 64'd0
            || alu_opcode !== 4'd0) begin
            n_fail++;
            $display("FAIL mr_alu got=%b %h %h %h want=0 0 0 0",
                     alu_valid, alu_op_a, alu_op_b, alu_opcode);
        end
        n_checks++;
        if (resp_valid !== 1'b0 || resp_id !== 2'd0 || resp_tag !== 4'd0
            || resp_result !== 64'd0) begin
            n_fail++;
            $display("FAIL mr_resp got=%b %0d %0d %h want=0 0 0 0",
                     resp_valid, resp_id, resp_tag, resp_result);
        end
        n_checks++;
        if (busy !== 1'b0 || flush_done !== 1'b0 || req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL mr_ctrl got=%b %b %b want=0 0 0000",
                     busy, flush_done, req_ready);
        end
        for (int c = 0; c < 4; c++) begin
            step();
            n_checks++;
            if (resp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL mr_ghost c=%0d got=%b want=0", c, resp_valid);
            end
        end
        for (int i = 0; i < 4; i++) begin
            set_req(i, 64'd1, 64'd1, OP_ADD, 4'd0);
        end
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL mr_ptr got=%b want=0001", req_ready);
        end
        step();
        clear_reqs();
        for (int c = 0; c < 4; c++) step();
    endtask

    initial begin
        clear_reqs();
        flush_req = 1'b0;
        rst = 1'b0;
        alu_result = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_back_to_back();
        test_flush();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
